// File: rtl/gpio_pad_ctrl.sv
// Pad-side GPIO stage: registers the pad drive, synchronises pad inputs,
// detects per-bit edges and holds sticky W1C interrupt status behind a small register port.
module gpio_pad_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpio_out,
    input  logic [WIDTH-1:0] gpio_oe,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    input  logic [3:0]       addr,
    input  logic [31:0]      wdata,
    input  logic             wen,
    output logic [31:0]      rdata,
    output logic             irq
);

    localparam logic [3:0] ADDR_DATA_IN = 4'h0;
    localparam logic [3:0] ADDR_RISE_EN = 4'h4;
    localparam logic [3:0] ADDR_FALL_EN = 4'h8;
    localparam logic [3:0] ADDR_STATUS  = 4'hC;

    logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] status;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] status_set;
    logic [WIDTH-1:0] status_clr;

    assign sync_q = sync_ff[SYNC_STAGES-1];
    assign rise   = sync_q & ~prev;
    assign fall   = ~sync_q & prev;

    // Edges are qualified by the enables held this cycle, so an enable written
    // now only affects edges seen from the next cycle onward.
    assign status_set = (rise & rise_en) | (fall & fall_en);
    assign status_clr = (wen && (addr == ADDR_STATUS)) ? wdata[WIDTH-1:0] : '0;

    // Status is a flop, so irq has no combinational path back to pad_in.
    assign irq = |status;

    // NOTE: all state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_out <= '0;
            pad_oe  <= '0;
        end else begin
            pad_out <= gpio_out;
            pad_oe  <= gpio_oe;
        end
    end

    // NOTE: the synchroniser array is reset too; with it at 0 the first
    // post-reset sample of a high pad looks like a rise, which the
    // reset-cleared enables mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= '0;
            end
            prev <= '0;
        end else begin
            sync_ff[0] <= pad_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
            prev <= sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
        end else begin
            if (wen && (addr == ADDR_RISE_EN)) begin
                rise_en <= wdata[WIDTH-1:0];
            end
            if (wen && (addr == ADDR_FALL_EN)) begin
                fall_en <= wdata[WIDTH-1:0];
            end
            // Set is OR-ed in after the clear, so a same-cycle edge wins.
            status <= (status & ~status_clr) | status_set;
        end
    end

    // NOTE: rdata gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_DATA_IN: rdata[WIDTH-1:0] = sync_q;
            ADDR_RISE_EN: rdata[WIDTH-1:0] = rise_en;
            ADDR_FALL_EN: rdata[WIDTH-1:0] = fall_en;
            ADDR_STATUS:  rdata[WIDTH-1:0] = status;
            default:      rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl: table of per-cycle register/pad vectors
// plus hand-written reset and output-path sequences.
module tb_gpio_pad_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  gpio_oe;
    logic [W-1:0]  pad_in;
    logic [W-1:0]  pad_out;
    logic [W-1:0]  pad_oe;
    logic [3:0]    addr;
    logic [31:0]   wdata;
    logic          wen;
    logic [31:0]   rdata;
    logic          irq;

    always #5 clk = ~clk;

    gpio_pad_ctrl #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .pad_in   (pad_in),
        .pad_out  (pad_out),
        .pad_oe   (pad_oe),
        .addr     (addr),
        .wdata    (wdata),
        .wen      (wen),
        .rdata    (rdata),
        .irq      (irq)
    );

    typedef struct {
        string       name;
        logic [3:0]  addr;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] pad;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [3:0] a, input logic w,
                       input logic [31:0] d, input logic [31:0] p,
                       input logic [31:0] er, input logic ei);
        vec_t v;
        v.name = name; v.addr = a; v.wen = w; v.wdata = d; v.pad = p;
        v.exp_rdata = er; v.exp_irq = ei;
        vecs.push_back(v);
    endtask

    // One vector = inputs driven at negedge, one posedge, outputs checked 1 time unit later.
    task automatic apply(input vec_t v);
        @(negedge clk);
        addr   = v.addr;
        wen    = v.wen;
        wdata  = v.wdata;
        pad_in = v.pad;
        @(posedge clk);
        #1;
        check({v.name, "_rdata"}, rdata, v.exp_rdata);
        check({v.name, "_irq"}, {31'b0, irq}, {31'b0, v.exp_irq});
    endtask

    initial begin
        // name, addr, wen, wdata, pad_in, expected rdata, expected irq
        add("rise_en_wr",       4'h4, 1, 32'h1,   32'h000, 32'h1,   0);
        add("rise_e0",          4'h0, 0, 32'h0,   32'h001, 32'h0,   0);
        add("rise_e1_data",     4'h0, 0, 32'h0,   32'h001, 32'h1,   0);
        add("rise_e2_status",   4'hC, 0, 32'h0,   32'h001, 32'h1,   1);
        add("rise_w1c",         4'hC, 1, 32'h1,   32'h001, 32'h0,   0);
        add("fall_rise_en_off", 4'h4, 1, 32'h0,   32'h301, 32'h0,   0);
        add("fall_en_wr",       4'h8, 1, 32'h100, 32'h301, 32'h100, 0);
        add("fall_hi_data",     4'h0, 0, 32'h0,   32'h301, 32'h301, 0);
        add("fall_e0",          4'hC, 0, 32'h0,   32'h001, 32'h0,   0);
        add("fall_e1",          4'hC, 0, 32'h0,   32'h001, 32'h0,   0);
        add("fall_e2_status",   4'hC, 0, 32'h0,   32'h001, 32'h100, 1);
        add("fall_bit9_masked", 4'hC, 0, 32'h0,   32'h001, 32'h100, 1);
        add("coll_clr8",        4'hC, 1, 32'h100, 32'h001, 32'h0,   0);
        add("coll_rise_en",     4'h4, 1, 32'h8,   32'h001, 32'h8,   0);
        add("coll_up_e0",       4'hC, 0, 32'h0,   32'h009, 32'h0,   0);
        add("coll_up_e1",       4'hC, 0, 32'h0,   32'h009, 32'h0,   0);
        add("coll_bit3_set",    4'hC, 0, 32'h0,   32'h009, 32'h8,   1);
        add("coll_down_e0",     4'hC, 0, 32'h0,   32'h001, 32'h8,   1);
        add("coll_down_e1",     4'hC, 0, 32'h0,   32'h001, 32'h8,   1);
        add("coll_up2_e0",      4'hC, 0, 32'h0,   32'h009, 32'h8,   1);
        add("coll_up2_e1",      4'hC, 0, 32'h0,   32'h009, 32'h8,   1);
        add("coll_set_wins",    4'hC, 1, 32'h8,   32'h009, 32'h8,   1);
        add("coll_clear",       4'hC, 1, 32'h8,   32'h009, 32'h0,   0);
        add("ro_wr_data_in",    4'h0, 1, 32'hFFFF_FFFF, 32'h009, 32'h9, 0);
        add("unmapped_wr_rd",   4'h2, 1, 32'hFFFF_FFFF, 32'h009, 32'h0, 0);
        add("rd_rise_en",       4'h4, 0, 32'h0,   32'h009, 32'h8,   0);
        add("rd_fall_en",       4'h8, 0, 32'h0,   32'h009, 32'h100, 0);
        add("rd_status",        4'hC, 0, 32'h0,   32'h009, 32'h0,   0);
        add("both_fall_en",     4'h8, 1, 32'h8,   32'h009, 32'h8,   0);
        add("both_down_e0",     4'hC, 0, 32'h0,   32'h001, 32'h0,   0);
        add("both_down_e1",     4'hC, 0, 32'h0,   32'h001, 32'h0,   0);
        add("both_fall_set",    4'hC, 0, 32'h0,   32'h009, 32'h8,   1);
        add("both_up_e1",       4'hC, 0, 32'h0,   32'h009, 32'h8,   1);
        add("both_rise_sticky", 4'hC, 0, 32'h0,   32'h009, 32'h8,   1);
        add("en_clr_keeps_pend",4'h8, 1, 32'h0,   32'h009, 32'h0,   1);
        add("pend_clear",       4'hC, 1, 32'h8,   32'h009, 32'h0,   0);
        add("en_up_e0",         4'hC, 0, 32'h0,   32'h00B, 32'h0,   0);
        add("en_up_e1",         4'hC, 0, 32'h0,   32'h00B, 32'h0,   0);
        add("en_same_cycle",    4'h4, 1, 32'hA,   32'h00B, 32'hA,   0);
        add("en_old_used",      4'hC, 0, 32'h0,   32'h00B, 32'h0,   0);

        // Reset with the drive inputs active: outputs must still be held at 0.
        rst_n    = 1'b0;
        gpio_out = '1;
        gpio_oe  = '1;
        pad_in   = '0;
        addr     = 4'h0;
        wdata    = '0;
        wen      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pad_out", pad_out, 32'h0);
        check("rst_pad_oe", pad_oe, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        for (int a = 0; a < 16; a += 4) begin
            addr = 4'(a);
            #1;
            check("rst_rdata", rdata, 32'h0);
        end

        @(negedge clk);
        gpio_out = '0;
        gpio_oe  = '0;
        rst_n    = 1'b1;
        @(negedge clk);
        gpio_out = 32'hA5A5_0F0F;
        gpio_oe  = 32'hFFFF_0000;
        #1;
        check("out_before_edge", pad_out, 32'h0);
        check("oe_before_edge", pad_oe, 32'h0);
        @(posedge clk);
        #1;
        check("out_after_edge", pad_out, 32'hA5A5_0F0F);
        check("oe_after_edge", pad_oe, 32'hFFFF_0000);

        foreach (vecs[i]) apply(vecs[i]);

        check("pad_out_held", pad_out, 32'hA5A5_0F0F);

        // Build STATUS=0xF with every enable set and all pads driven, then reset mid-run.
        @(negedge clk);
        gpio_oe = '1;
        wen     = 1'b1;
        addr    = 4'h4;
        wdata   = 32'hF;
        @(negedge clk);
        addr    = 4'h8;
        @(negedge clk);
        wen     = 1'b0;
        addr    = 4'hC;
        pad_in  = 32'h4;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_pre_status", rdata, 32'hF);
        check("midrst_pre_irq", {31'b0, irq}, 32'h1);
        check("midrst_pre_oe", pad_oe, 32'hFFFF_FFFF);

        @(negedge clk);
        rst_n  = 1'b0;
        pad_in = '1;
        #1;
        check("midrst_irq", {31'b0, irq}, 32'h0);
        check("midrst_status", rdata, 32'h0);
        check("midrst_oe", pad_oe, 32'h0);
        check("midrst_out", pad_out, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_status", rdata, 32'h0);
        check("post_rst_irq", {31'b0, irq}, 32'h0);
        addr = 4'h0;
        #1;
        check("post_rst_data_in", rdata, 32'hFFFF_FFFF);
        addr = 4'h4;
        #1;
        check("post_rst_rise_en", rdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_pad_ctrl.md
Name: gpio_pad_ctrl

Overview:
- Pad-side stage directly downstream of the GPIO output/enable register block.
- Registers gpio_out/gpio_oe into glitch-free pad drive signals.
- Synchronises pad inputs, detects per-bit rising/falling edges and holds sticky W1C interrupt status.
- Exposes input data, edge enables and status on the same addr/wdata/wen/rdata register-port style as the GPIO register block; drives one level interrupt to the core.

Parameters:
- WIDTH, 32, number of GPIO bits (1..32).
- SYNC_STAGES, 2, flops in the input synchroniser chain (>=2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- gpio_out  input  WIDTH  output value from the GPIO register block.
- gpio_oe  input  WIDTH  output enable from the GPIO register block (1 = drive).
- pad_in  input  WIDTH  raw asynchronous pad input.
- pad_out  output  WIDTH  registered pad drive value.
- pad_oe  output  WIDTH  registered pad output enable.
- addr  input  4  byte offset: 0x0, 0x4, 0x8, 0xC.
- wdata  input  32  write data.
- wen  input  1  write strobe, one write per asserted cycle.
- rdata  output  32  combinational readback for addr.
- irq  output  1  level interrupt, OR of status bits.

Behaviour:
- Reset (async, rst_n low):
  - pad_out, pad_oe, synchroniser flops, prev-sample register, RISE_EN, FALL_EN and STATUS all clear to 0.
  - irq=0.
  - rdata reflects cleared registers.
- Output path:
  - pad_out <= gpio_out and pad_oe <= gpio_oe on every clk edge.
  - Fixed 1-cycle latency; no other logic on this path.
- Input path:
  - pad_in passes through SYNC_STAGES flops per bit; the last stage is sync_q.
  - Pad value is sampled regardless of pad_oe, so driven pins read back their own value.
- Edge detect:
  - prev <= sync_q every cycle.
  - rise = sync_q & ~prev; fall = ~sync_q & prev.
- Latency (SYNC_STAGES=2), pad_in stable before edge E0:
  - sync_q updates at E1; DATA_IN shows the new value after E1.
  - STATUS bit sets at E2; irq high after E2.
- Minimum pulse width:
  - Pulses shorter than one clk period may be missed; this is not an error.
  - Pulses of at least SYNC_STAGES+1 clk periods are always captured.
- Registers (bits above WIDTH read 0, ignore writes):
  - 0x0 DATA_IN: RO, sync_q. Writes are ignored.
  - 0x4 RISE_EN: RW, per-bit rising-edge enable.
  - 0x8 FALL_EN: RW, per-bit falling-edge enable.
  - 0xC STATUS: RW1C. Sets next cycle when (rise & RISE_EN) | (fall & FALL_EN).
  - Other addresses: rdata=0, writes ignored.
- STATUS rules:
  - Writing 1 clears a bit; writing 0 has no effect.
  - Set and clear on the same bit in the same cycle: set wins, bit stays 1.
  - Bits are sticky until cleared.
  - Clearing an enable does not clear its pending status.
  - An enable written in cycle N qualifies edges from cycle N+1 onward; the edge in cycle N uses the old enable.
- irq:
  - irq = |STATUS, registered-to-output with no added combinational path from pad_in.
  - Deasserts the cycle after the last status bit clears.
- Post-reset spurious edge:
  - prev and the sync chain reset to 0, so a pad held high produces a "rise" SYNC_STAGES cycles after reset.
  - It is masked because the enables reset to 0.
  - Software must clear STATUS after enabling, if desired.
- Reset mid-operation:
  - All state clears immediately, including pending status and pad drive.
  - pad_oe=0 releases the pads.
- Both edges enabled: a pulse sets the bit once (sticky); bit remains 1.

Test Plan:
- Reset then output path:
  - Stimulus: assert rst_n low; release; set gpio_out=0xA5A5_0F0F, gpio_oe=0xFFFF_0000.
  - Response: pad_out/pad_oe read 0 during reset; exactly one cycle after the inputs are applied, pad_out=0xA5A5_0F0F and pad_oe=0xFFFF_0000.
- Rising-edge interrupt:
  - Stimulus: write RISE_EN(0x4)=0x0000_0001; toggle pad_in[0] 0->1 before E0.
  - Response: DATA_IN bit0=1 after E1; STATUS=0x1 and irq=1 after E2. Write 0xC=0x1 -> STATUS=0 and irq=0 next cycle.
- Falling edge, masked bit:
  - Stimulus: FALL_EN=0x0000_0100, RISE_EN=0; pulse pad_in[8] 1->0 and pad_in[9] 1->0.
  - Response: STATUS=0x0000_0100 only; bit9 stays 0.
- Set/clear collision:
  - Stimulus: with STATUS bit3 already 1, a new bit3 edge arrives in the same cycle as a write of 0xC=0x8.
  - Response: STATUS bit3 remains 1 and irq stays 1.
- Unmapped/RO writes:
  - Stimulus: write 0x0=0xFFFF_FFFF, then read 0x2.
  - Response: DATA_IN is unchanged and 0x2 reads 0.
- Reset mid-operation:
  - Stimulus: with STATUS=0xF, enables set and pad_oe=all-ones, pulse rst_n low.
  - Response: immediately irq=0, STATUS=0, pad_oe=0.
  - After release, pad_in held high gives no status set.
